// File: rtl/uart_tx_serializer_if.sv
// Line-transmit handshake between the upstream message memory and the UART serializer.
// master = upstream/driver side, slave = serializer side.
interface uart_tx_serializer_if;
  logic       iTX_START;
  logic [7:0] iTX_DATA;
  logic       oTX_REQ;
  logic       oFINISH;
  logic       oTX;
  logic       oBUSY;
  logic [5:0] oBYTE_CNT;

  modport master (
    output iTX_START, iTX_DATA,
    input  oTX_REQ, oFINISH, oTX, oBUSY, oBYTE_CNT
  );

  modport slave (
    input  iTX_START, iTX_DATA,
    output oTX_REQ, oFINISH, oTX, oBUSY, oBYTE_CNT
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Fetches LINE_BYTES bytes from upstream memory and sends each as an 8N1 UART frame.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LINE_BYTES   = 35,
  parameter int FETCH_WAIT   = 2
) (
  input  logic clk,
  input  logic reset,
  uart_tx_serializer_if.slave bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WW = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

  state_t          r_state, w_next;
  logic            r_start_d;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [WW-1:0]   r_wait;
  logic [7:0]      r_shift;
  logic [5:0]      r_cnt;
  logic            r_tx;
  logic            w_tx_nxt;
  logic            w_rise, w_baud_last, w_wait_last, w_line_end, w_in_frame;
  logic [2:0]      w_bit_nxt;

  assign w_rise      = bus.iTX_START & ~r_start_d;
  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_wait_last = (r_wait == WW'(FETCH_WAIT - 1));
  // Dropping iTX_START is only honoured at a byte boundary, so a frame is never cut short.
  assign w_line_end  = ((r_cnt + 6'd1) == 6'(LINE_BYTES)) || !bus.iTX_START;
`ifdef TX_PARITY_EN
  assign w_in_frame  = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
`else
  assign w_in_frame  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_nxt  = 1'b1;
    w_bit_nxt = (r_state == S_DATA && w_baud_last) ? r_bit + 3'd1 : r_bit;
    case (r_state)
      S_IDLE:   if (w_rise) w_next = S_FETCH;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   if (w_wait_last) w_next = S_START;
      S_START:  if (w_baud_last) w_next = S_DATA;
`ifdef TX_PARITY_EN
      S_DATA:   if (w_baud_last && r_bit == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_baud_last) w_next = S_STOP;
`else
      S_DATA:   if (w_baud_last && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP:   if (w_baud_last) w_next = w_line_end ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // Line level is derived from the next state so oTX can be a plain flop.
    case (w_next)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_shift[w_bit_nxt];
`ifdef TX_PARITY_EN
      S_PARITY: w_tx_nxt = ^r_shift;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_d <= 1'b1;  // a start already high at release is not a rising edge
      r_baud    <= '0;
      r_bit     <= '0;
      r_wait    <= '0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_start_d <= bus.iTX_START;
      r_tx      <= w_tx_nxt;
      r_baud    <= (w_in_frame && !w_baud_last) ? r_baud + BW'(1) : '0;
      r_wait    <= (r_state == S_WAIT && !w_wait_last) ? r_wait + WW'(1) : '0;
      if (r_state == S_DATA && w_baud_last) r_bit <= r_bit + 3'd1;
      if (r_state == S_WAIT && w_wait_last) r_shift <= bus.iTX_DATA;
      if (r_state == S_IDLE && w_rise) r_cnt <= '0;
      else if (r_state == S_STOP && w_baud_last) r_cnt <= r_cnt + 6'd1;
    end
  end

  assign bus.oTX       = r_tx;
  assign bus.oTX_REQ   = (r_state == S_FETCH);
  assign bus.oFINISH   = (r_state == S_DONE);
  assign bus.oBUSY     = (r_state != S_IDLE);
  assign bus.oBYTE_CNT = r_cnt;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: upstream memory model feeds a byte table, a UART
// receiver decodes oTX mid-bit and checks each frame against a scoreboard queue.
module tb_uart_tx_serializer;
  localparam int CPB = 4;
  localparam int LB  = 3;
  localparam int FW  = 2;
  localparam int NV  = 6;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 is first on the line: start, d0..d7, stop
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  uart_tx_serializer_if bus();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .LINE_BYTES(LB), .FETCH_WAIT(FW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  vec_t        tbl [NV];
  logic [10:0] sb_q [$];
  int          req_total = 0, fin_total = 0, line_req = 0, tp = 0, cyc = 0, req_cyc = 0;
  bit          corrupt_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream memory model plus serial receiver, both sampling on the falling edge.
  initial begin : model
    logic prev_tx, prev_req, in_frame;
    int phase;
    logic [10:0] frame, exp;
    prev_tx = 1'b1; prev_req = 1'b0; in_frame = 1'b0; phase = 0; frame = '0;
    bus.iTX_DATA = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb_q.delete();
        in_frame = 1'b0; prev_tx = 1'b1; prev_req = 1'b0; line_req = 0;
      end else begin
        if (bus.oTX_REQ) begin
          chk("req_one_cycle", prev_req, 0);
          chk("cnt_at_req", bus.oBYTE_CNT, line_req);
          bus.iTX_DATA = tbl[tp].data;
`ifdef TX_PARITY_EN
          sb_q.push_back({1'b1, tbl[tp].par, tbl[tp].frame[8:0]});
`else
          sb_q.push_back({1'b0, tbl[tp].frame});
`endif
          tp = (tp + 1) % NV; line_req++; req_total++; req_cyc = cyc;
        end
        if (bus.oFINISH) begin
          fin_total++; line_req = 0;
        end
        if (!in_frame && prev_tx && !bus.oTX) begin
          in_frame = 1'b1; phase = 0; frame = '0;
          chk("req_to_start", cyc - req_cyc, FW + 1);
          if (corrupt_en && line_req == 1) bus.iTX_DATA = 8'hAA;
        end else if (in_frame) begin
          phase++;
        end
        if (in_frame && (phase % CPB) == CPB / 2) begin
          frame[phase / CPB] = bus.oTX;
          if (phase / CPB == NB - 1) begin
            in_frame = 1'b0;
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
              exp = sb_q.pop_front();
              chk("frame", frame, exp);
            end
          end
        end
        prev_tx = bus.oTX; prev_req = bus.oTX_REQ;
      end
    end
  end

  task automatic wait_fin(input int maxc, input string name);
    int n = 0;
    while (bus.oFINISH !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    chk(name, bus.oFINISH, 1);
  endtask

  task automatic wait_req(input int target, input int maxc);
    int n = 0;
    while (req_total < target && n < maxc) begin @(negedge clk); n++; end
    chk("req_seen", req_total >= target, 1);
  endtask

  task automatic wait_fall(input int maxc);
    int n = 0;
    while (bus.oTX !== 1'b0 && n < maxc) begin @(negedge clk); n++; end
    chk("start_seen", bus.oTX, 0);
  endtask

  initial begin : main
    int base, bfin;
    tbl[0] = '{8'h63, 10'b1011000110, 1'b0};
    tbl[1] = '{8'h61, 10'b1011000010, 1'b1};
    tbl[2] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[3] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[4] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[5] = '{8'h80, 10'b1100000000, 1'b1};

    reset = 1'b1; bus.iTX_START = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.oTX, 1);
    chk("rst_req", bus.oTX_REQ, 0);
    chk("rst_fin", bus.oFINISH, 0);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_cnt", bus.oBYTE_CNT, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full lines straight from the table
    for (int l = 0; l < 2; l++) begin
      base = req_total; bfin = fin_total;
      bus.iTX_START = 1'b1;
      wait_fin(400, "line_finish");
      chk("line_cnt", bus.oBYTE_CNT, LB);
      @(negedge clk);
      chk("line_busy_after", bus.oBUSY, 0);
      chk("line_fin_pulse", bus.oFINISH, 0);
      chk("line_fin_count", fin_total - bfin, 1);
      repeat (20) @(negedge clk);
      chk("line_reqs_no_restart", req_total - base, LB);
      bus.iTX_START = 1'b0;
      @(negedge clk);
    end

    // Start re-rise while busy is ignored
    base = req_total;
    bus.iTX_START = 1'b1;
    wait_req(base + 2, 200);
    wait_fall(50);
    repeat (6) @(negedge clk);
    bus.iTX_START = 1'b0;
    @(negedge clk);
    bus.iTX_START = 1'b1;
    wait_fin(400, "blip_finish");
    chk("blip_cnt", bus.oBYTE_CNT, LB);
    repeat (20) @(negedge clk);
    chk("blip_reqs", req_total - base, LB);
    bus.iTX_START = 1'b0;
    @(negedge clk);

    // Abort: start drops during bit 3 of byte 2
    base = req_total;
    bus.iTX_START = 1'b1;
    wait_req(base + 2, 200);
    wait_fall(50);
    repeat (17) @(negedge clk);
    bus.iTX_START = 1'b0;
    wait_fin(200, "abort_finish");
    chk("abort_cnt", bus.oBYTE_CNT, 2);
    repeat (30) @(negedge clk);
    chk("abort_reqs", req_total - base, 2);
    chk("abort_idle", bus.oBUSY, 0);

    // Upstream data changes after capture; the frame must keep the fetched byte
    corrupt_en = 1'b1;
    base = req_total;
    bus.iTX_START = 1'b1;
    wait_fin(400, "capture_finish");
    corrupt_en = 1'b0;
    @(negedge clk);
    chk("capture_reqs", req_total - base, LB);
    bus.iTX_START = 1'b0;
    @(negedge clk);

    // Reset during DATA bit 5
    base = req_total; bfin = fin_total;
    bus.iTX_START = 1'b1;
    wait_req(base + 1, 100);
    wait_fall(50);
    repeat (25) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_tx", bus.oTX, 1);
    chk("midrst_busy", bus.oBUSY, 0);
    chk("midrst_req", bus.oTX_REQ, 0);
    chk("midrst_cnt", bus.oBYTE_CNT, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_restart", req_total - base, 1);
    chk("midrst_no_finish", fin_total - bfin, 0);
    chk("midrst_idle", bus.oBUSY, 0);
    bus.iTX_START = 1'b0;
    repeat (2) @(negedge clk);
    base = req_total;
    bus.iTX_START = 1'b1;
    wait_fin(400, "restart_finish");
    chk("restart_cnt", bus.oBYTE_CNT, LB);
    @(negedge clk);
    chk("restart_reqs", req_total - base, LB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
